// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse message scheduler.
package morse_pkg;

    // Sequencer states; IDLE must stay the all-zero encoding so reset and flush share it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MARK  = 3'd2,
        SPACE = 3'd3,
        LGAP  = 3'd4
    } state_t;

    // Letter codes as typed on the switches.
    localparam logic [2:0] LTR_A = 3'd0;
    localparam logic [2:0] LTR_B = 3'd1;
    localparam logic [2:0] LTR_C = 3'd2;
    localparam logic [2:0] LTR_D = 3'd3;
    localparam logic [2:0] LTR_E = 3'd4;
    localparam logic [2:0] LTR_F = 3'd5;
    localparam logic [2:0] LTR_G = 3'd6;
    localparam logic [2:0] LTR_H = 3'd7;

    // Durations in Morse time units.
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int SYM_GAP    = 1;
    localparam int LTR_GAP    = 3;

    // Value of the 2-bit unit counter on the final tick of a phase lasting 'units' ticks.
    function automatic logic [1:0] last_unit(input int units);
        return 2'(units - 1);
    endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// Letter code to Morse pattern lookup. Pattern is MSB-first, 1 = dash, 0 = dot,
// left-aligned in 4 bits; length is the number of valid symbols.
module morse_letter_rom
    import morse_pkg::*;
(
    input  logic [2:0] i_letter,
    output logic [3:0] o_pattern,
    output logic [2:0] o_length
);

    // Pure table lookup.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
        o_pattern = 4'b0000;
        o_length  = 3'd1;
        case (i_letter)
            LTR_A: begin o_pattern = 4'b0100; o_length = 3'd2; end
            LTR_B: begin o_pattern = 4'b1000; o_length = 3'd4; end
            LTR_C: begin o_pattern = 4'b1010; o_length = 3'd4; end
            LTR_D: begin o_pattern = 4'b1000; o_length = 3'd3; end
            LTR_E: begin o_pattern = 4'b0000; o_length = 3'd1; end
            LTR_F: begin o_pattern = 4'b0010; o_length = 3'd4; end
            LTR_G: begin o_pattern = 4'b1100; o_length = 3'd3; end
            LTR_H: begin o_pattern = 4'b0000; o_length = 3'd4; end
            default: begin o_pattern = 4'b0000; o_length = 3'd1; end
        endcase
    end

endmodule

// File: rtl/morse_msg_scheduler.sv
// Letter FIFO plus Morse symbol sequencer driving a single LED.
// The FIFO lets the user queue letters while the current one is still being sent.
module morse_msg_scheduler
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int DEPTH    = 8,
    parameter int AW       = 3
)(
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          push,
    input  logic [2:0]    letter,
    input  logic          flush,
    output logic          led,
    output logic          busy,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          done,
    output logic          ovf
);

    localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_MAX = CW'(TICK_DIV - 1);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_units;
    logic [3:0]      r_sh;
    logic [2:0]      r_rem;
    logic            r_led;
    logic            r_done;
    logic            r_ovf;

    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;

    logic            w_tick;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;
    logic [3:0]      w_pattern;
    logic [2:0]      w_length;

    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == '0);
    // LOAD always sees a non-empty FIFO, so the pop needs no empty guard.
    assign w_pop     = (r_state == LOAD) && !flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push_ok = push && !flush && (!w_full || w_pop);
    // Pushes lost to flush are silent; only capacity drops raise ovf.
    assign w_drop    = push && !flush && !w_push_ok;
    assign w_tick    = (r_state != IDLE) && (r_state != LOAD) && (r_cnt == TICK_MAX);

    assign led   = r_led;
    assign busy  = (r_state != IDLE);
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign done  = r_done;
    assign ovf   = r_ovf;

    morse_letter_rom u_rom (
        .i_letter  (r_mem[r_rd_ptr]),
        .o_pattern (w_pattern),
        .o_length  (w_length)
    );

    // Letter storage: written on accepted pushes only.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: the data array has no reset; pointers and level alone decide what is valid.
        if (w_push_ok)
            r_mem[r_wr_ptr] <= letter;
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_ovf <= w_drop;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Unit prescaler: held at zero outside the timed states so each unit is exactly TICK_DIV cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset || flush || r_state == IDLE || r_state == LOAD)
            r_cnt <= '0;
        else if (r_cnt == TICK_MAX)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    // Symbol sequencer with registered led and done.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
            r_units <= '0;
            r_sh    <= '0;
            r_rem   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_units <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty)
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_sh    <= w_pattern;
                    r_rem   <= w_length;
                    r_units <= '0;
                    r_led   <= 1'b1;
                    r_state <= MARK;
                end
                MARK: begin
                    if (w_tick) begin
                        if (r_units == (r_sh[3] ? last_unit(DASH_UNITS) : last_unit(DOT_UNITS))) begin
                            r_units <= '0;
                            r_sh    <= {r_sh[2:0], 1'b0};
                            r_rem   <= r_rem - 3'd1;
                            r_led   <= 1'b0;
                            r_state <= (r_rem != 3'd1) ? SPACE : LGAP;
                        end else begin
                            r_units <= r_units + 2'd1;
                        end
                    end
                end
                SPACE: begin
                    if (w_tick) begin
                        if (r_units == last_unit(SYM_GAP)) begin
                            r_units <= '0;
                            r_led   <= 1'b1;
                            r_state <= MARK;
                        end else begin
                            r_units <= r_units + 2'd1;
                        end
                    end
                end
                LGAP: begin
                    if (w_tick) begin
                        if (r_units == last_unit(LTR_GAP)) begin
                            r_units <= '0;
                            r_done  <= 1'b1;
                            r_state <= w_empty ? IDLE : LOAD;
                        end else begin
                            r_units <= r_units + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/morse_msg_scheduler.md
Name: morse_msg_scheduler

Overview:
- Queues up to DEPTH 3-bit letter codes (A..H = 3'b000..3'b111) and plays them back-to-back on one LED as Morse code.
- Sequences the single Morse symbol engine and its time-unit prescaler, so a user can type a message while the previous letter is still being sent.
- Sits between the switch/key input logic and LEDR[0] at board top level.

Parameters:
- TICK_DIV, 25000000, CLOCK_50 cycles per Morse time unit (0.5 s); the bench uses 4.
- DEPTH, 8, letter FIFO depth; must be a power of two, at least 2.
- AW, 3, log2(DEPTH).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- push  in  1  one-cycle write strobe for letter.
- letter  in  3  letter code, sampled when push=1.
- flush  in  1  abort the current letter and empty the FIFO.
- led  out  1  Morse output; 1 = mark.
- busy  out  1  1 whenever state != IDLE.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  AW+1  number of queued letters, excluding the one being played.
- done  out  1  one-cycle pulse at the end of each letter's trailing gap.
- ovf  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset: clock-synchronous, active-high (reset on CLOCK_50). All outputs are 0, except empty=1. FIFO pointers, tick counter and state are cleared. Reset takes priority over every other input on any cycle.
- Letter table (pattern MSB-first, 1 = dash, 0 = dot; length):
  - A .- (len 2), B -... (4), C -.-. (4), D -.. (3)
  - E . (1), F ..-. (4), G --. (3), H .... (4)
- Unit tick: the counter runs 0..TICK_DIV-1 only while state is not IDLE or LOAD. It is forced to 0 in LOAD. The tick is a single-cycle pulse when count == TICK_DIV-1, so every unit is exactly TICK_DIV cycles.
- States:
  - IDLE: if !empty, go to LOAD.
  - LOAD (1 cycle): pop the FIFO head; latch its pattern into shift reg sh[3:0] and its length into rem[2:0]; go to MARK.
  - MARK: hold for 1 tick if sh[3]=0, 3 ticks if sh[3]=1. Then shift sh left with 0 fill and decrement rem. Go to SPACE if rem (after decrement) != 0, else go to LGAP.
  - SPACE: 1 tick, then MARK.
  - LGAP: 3 ticks. On exit, pulse done. Go to LOAD if !empty, else IDLE.
- led is registered and equals 1 exactly during MARK.
- Latency: a push while IDLE and empty, at edge t, gives level=1 at t+1, LOAD at t+2, and led=1 from t+3.
- FIFO write and pop:
  - A push is accepted if !full, or if a pop (LOAD) happens in the same cycle.
  - Otherwise the push is dropped and ovf pulses on the next cycle.
  - Push and pop in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
- flush:
  - Empties the FIFO and returns to IDLE on the next edge; led drops to 0 there and done does not pulse.
  - A push in the same cycle as flush is discarded, without ovf.
- Counter widths: the tick counter is wide enough for TICK_DIV-1; the unit counter is 2 bits (max 3).

Decomposition:
- Package morse_pkg holds:
  - state encodings IDLE, LOAD, MARK, SPACE, LGAP;
  - letter-code constants;
  - DOT_UNITS=1, DASH_UNITS=3, SYM_GAP=1, LTR_GAP=3.
- One sub-module, morse_letter_rom: combinational letter code -> pattern[3:0], length[2:0].
- FIFO and FSM stay inline.

Test Plan (TICK_DIV=4):
- Push E while idle -> led high for 4 cycles starting 3 cycles after the push; low 12 cycles; done pulses; busy=0 afterwards; level returns to 0.
- Push A -> led pattern 4 high, 4 low, 12 high, 12 low (in cycles); exactly one done pulse.
- Push C then E on consecutive cycles -> level reaches 1 while C plays; E starts immediately after C's 12-cycle gap with no IDLE cycle; two done pulses.
- Push 9 letters while the first is playing -> 8 queued, full=1; the 9th push gives an ovf pulse; a push in a LOAD cycle while full is accepted, level stays 8.
- Assert flush mid-dash of B with 3 queued -> next edge: led=0, state IDLE, level=0, empty=1, no done pulse.
- Assert reset mid-playback -> all outputs at reset values on the next edge; a new push afterwards plays correctly from the first unit.
